// File: rtl/imem_boot_loader.sv
// Streams a big-endian length-prefixed program image into instruction memory and
// holds the core in reset until it is complete. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module imem_boot_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WLAST  = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK    = 3'd5;
`endif
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERROR  = 3'd7;

    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    localparam int unsigned       DEPTH = 1 << ADDR_W;

    logic [2:0]        state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [16:0]       rem_q, rem_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [23:0]       shift_q, shift_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [15:0]       len_n;
    logic              accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    always_comb begin
        in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
        in_ready = in_ready || (state_q == S_CHK);
`endif
    end

    assign accept       = in_valid && in_ready;
    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERROR);
    assign core_rst_n   = (state_q == S_DONE);
    assign imem_we      = imem_we_q;
    assign imem_waddr   = waddr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = words_q;

    always_comb begin
        state_d   = state_q;
        len_hi_d  = len_hi_q;
        rem_d     = rem_q;
        bcnt_d    = bcnt_q;
        shift_d   = shift_q;
        imem_we_d = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        words_d   = words_q;
        len_n     = {len_hi_q, in_byte};
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif

        // Address/count advance the cycle after the strobe so both stay stable while imem_we is high.
        if (imem_we_q) begin
            waddr_d = waddr_q + 1'b1;
            words_d = words_q + 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LEN_HI;
                    waddr_d = BASE;
                    words_d = '0;
                    bcnt_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_hi_d = in_byte;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    rem_d = {1'b0, len_n};
                    if (len_n == 16'd0)
                        state_d = S_DONE;
                    else if (32'(len_n) > DEPTH)
                        state_d = S_ERROR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    bcnt_d  = bcnt_q + 2'd1;
                    shift_d = {shift_q[15:0], in_byte};
                    if (bcnt_q == 2'd3) begin
                        imem_we_d = 1'b1;
                        wdata_d   = {shift_q, in_byte};
                        rem_d     = rem_q - 17'd1;
                        if (rem_q == 17'd1)
                            state_d = S_WLAST;
                    end
                end
            end
            S_WLAST: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d = S_CHK;
`else
                state_d = S_DONE;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept)
                    state_d = (in_byte == csum_q) ? S_DONE : S_ERROR;
            end
`endif
            default: state_d = S_IDLE;
        endcase

`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept && (state_q != S_CHK))
            csum_d = csum_q ^ in_byte;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            len_hi_q  <= '0;
            rem_q     <= '0;
            bcnt_q    <= '0;
            shift_q   <= '0;
            imem_we_q <= 1'b0;
            waddr_q   <= BASE;
            wdata_q   <= '0;
            words_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_hi_q  <= len_hi_d;
            rem_q     <= rem_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            imem_we_q <= imem_we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            words_q   <= words_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: image loads, length boundaries, stalls, reset abort
// and (with IMEM_LOADER_CHECKSUM_EN) checksum accept/reject.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_byte = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  words_loaded;

    int vectors = 0;
    int miscompares = 0;

    int          wr_cnt = 0;
    logic [7:0]  wr_addr [0:31];
    logic [31:0] wr_data [0:31];

    imem_boot_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .core_rst_n(core_rst_n), .busy(busy), .done(done),
        .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_cnt < 32) begin
                wr_addr[wr_cnt] = imem_waddr;
                wr_data[wr_cnt] = imem_wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        in_byte  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $error("FAIL send_timeout: observed in_ready=0 expected in_ready=1 (byte %0h)", b);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic gap();
        @(posedge clk); #1;
    endtask

    task automatic wait_end();
        int n = 0;
        @(negedge clk);
        while (!(done || error) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("end_reached", 64'(done || error), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},   64'(in_ready),     64'd0);
        check({tag, "_imem_we"},    64'(imem_we),      64'd0);
        check({tag, "_waddr"},      64'(imem_waddr),   64'd0);
        check({tag, "_wdata"},      64'(imem_wdata),   64'd0);
        check({tag, "_core_rst_n"}, 64'(core_rst_n),   64'd0);
        check({tag, "_busy"},       64'(busy),         64'd0);
        check({tag, "_done"},       64'(done),         64'd0);
        check({tag, "_error"},      64'(error),        64'd0);
        check({tag, "_words"},      64'(words_loaded), 64'd0);
    endtask

    initial begin
        int base;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("idle");
        check("idle_no_writes", 64'(wr_cnt), 64'd0);
        #1;

        // Two-word image, back-to-back bytes
        base = wr_cnt;
        pulse_start();
        check("start_busy", 64'(busy), 64'd1);
        check("start_ready", 64'(in_ready), 64'd1);
        send(8'h00); send(8'h02);
        send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        send(8'h9A); send(8'hBC); send(8'hDE); send(8'hF0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h02);
`endif
        wait_end();
        check("w2_wr_count", 64'(wr_cnt - base), 64'd2);
        check("w2_addr0", 64'(wr_addr[base]), 64'h00);
        check("w2_data0", 64'(wr_data[base]), 64'h12345678);
        check("w2_addr1", 64'(wr_addr[base + 1]), 64'h01);
        check("w2_data1", 64'(wr_data[base + 1]), 64'h9ABCDEF0);
        check("w2_words", 64'(words_loaded), 64'd2);
        check("w2_waddr_next", 64'(imem_waddr), 64'd2);
        check("w2_done", 64'(done), 64'd1);
        check("w2_error", 64'(error), 64'd0);
        check("w2_core_rst_n", 64'(core_rst_n), 64'd1);
        check("w2_busy", 64'(busy), 64'd0);
        check("w2_in_ready", 64'(in_ready), 64'd0);
        #1;

        // Restart from DONE drops core reset immediately; zero-length image
        base = wr_cnt;
        pulse_start();
        check("restart_core_rst_n", 64'(core_rst_n), 64'd0);
        check("restart_done_clr", 64'(done), 64'd0);
        check("restart_words_clr", 64'(words_loaded), 64'd0);
        check("restart_waddr", 64'(imem_waddr), 64'd0);
        send(8'h00); send(8'h00);
        @(negedge clk);
        check("zero_done", 64'(done), 64'd1);
        check("zero_core_rst_n", 64'(core_rst_n), 64'd1);
        check("zero_no_writes", 64'(wr_cnt - base), 64'd0);
        check("zero_words", 64'(words_loaded), 64'd0);
        #1;

        // Length 257 exceeds a 256-word memory
        base = wr_cnt;
        pulse_start();
        send(8'h01); send(8'h01);
        @(negedge clk);
        check("oversize_error", 64'(error), 64'd1);
        check("oversize_done", 64'(done), 64'd0);
        check("oversize_core_rst_n", 64'(core_rst_n), 64'd0);
        check("oversize_in_ready", 64'(in_ready), 64'd0);
        check("oversize_no_writes", 64'(wr_cnt - base), 64'd0);
        #1;

        // One-word image with in_valid toggling
        base = wr_cnt;
        pulse_start();
        check("restart_err_clr", 64'(error), 64'd0);
        send(8'h00); gap(); send(8'h01); gap();
        send(8'hAA); gap(); send(8'hBB); gap();
        send(8'hCC); gap(); send(8'hDD); gap();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h01);
`endif
        wait_end();
        check("w1_wr_count", 64'(wr_cnt - base), 64'd1);
        check("w1_addr", 64'(wr_addr[base]), 64'h00);
        check("w1_data", 64'(wr_data[base]), 64'hAABBCCDD);
        check("w1_words", 64'(words_loaded), 64'd1);
        check("w1_done", 64'(done), 64'd1);
        check("w1_core_rst_n", 64'(core_rst_n), 64'd1);
        #1;

        // Length exactly 256 is accepted; then abort mid-word with rst
        base = wr_cnt;
        pulse_start();
        send(8'h01); send(8'h00);
        @(negedge clk);
        check("len256_error", 64'(error), 64'd0);
        check("len256_in_ready", 64'(in_ready), 64'd1);
        check("len256_busy", 64'(busy), 64'd1);
        #1;
        send(8'hAA); send(8'hBB);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        check("abort_no_writes", 64'(wr_cnt - base), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_abort");
        #1;

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum matches
        base = wr_cnt;
        pulse_start();
        send(8'h00); send(8'h01);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h45);
        wait_end();
        check("chk_ok_done", 64'(done), 64'd1);
        check("chk_ok_core_rst_n", 64'(core_rst_n), 64'd1);
        check("chk_ok_data", 64'(wr_data[base]), 64'h11223344);
        #1;

        // Checksum mismatch
        pulse_start();
        send(8'h00); send(8'h01);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h00);
        wait_end();
        check("chk_bad_error", 64'(error), 64'd1);
        check("chk_bad_done", 64'(done), 64'd0);
        check("chk_bad_core_rst_n", 64'(core_rst_n), 64'd0);
        #1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream of the 5-stage MIPS core: streams a program image from a byte channel into instruction-memory write port before the core runs.
- Holds the core in reset during load; releases it only after a complete, valid image is written.
- Replaces hard-coded instruction-memory init files for board bring-up.

Parameters:
- ADDR_W, 8, instruction-memory word-address width (depth = 2**ADDR_W words).
- BASE_ADDR, 0, first word address written (word-addressed, ADDR_W bits).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a new load.
- in_byte  input  8  incoming image byte.
- in_valid  input  1  in_byte valid.
- in_ready  output  1  loader accepts byte this cycle.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_waddr  output  ADDR_W  word address for write.
- imem_wdata  output  32  assembled instruction word.
- core_rst_n  output  1  active-low reset to core; 0 = core held.
- busy  output  1  load in progress.
- done  output  1  image loaded successfully (sticky until next start/rst).
- error  output  1  load aborted (sticky until next start/rst).
- words_loaded  output  ADDR_W+1  count of words written this load.

Behaviour:
- One clock, rst asynchronous active-high. Reset values: in_ready=0, imem_we=0, imem_waddr=BASE_ADDR, imem_wdata=0, core_rst_n=0, busy=0, done=0, error=0, words_loaded=0, state IDLE.
- Image format (big-endian): LEN_HI, LEN_LO (16-bit word count N), then 4*N bytes, MSB first per word.
- Byte accepted only when in_valid && in_ready; in_ready=1 exactly in states LEN_HI, LEN_LO, DATA (and CHK with option).
- States: IDLE -> (start) LEN_HI -> LEN_LO -> DATA -> DONE; any -> ERROR on fault.
- IDLE: start -> LEN_HI; clears done/error/words_loaded, imem_waddr=BASE_ADDR, core_rst_n=0, busy=1.
- LEN_LO accept: N==0 -> DONE; N > 2**ADDR_W -> ERROR; else DATA.
- DATA: 2-bit byte counter; on 4th accepted byte, imem_we=1 next cycle with imem_wdata/imem_waddr stable that cycle; imem_waddr then increments (wraps modulo 2**ADDR_W), words_loaded increments. Byte accept continues back-to-back; no bubble required.
- After Nth word's write strobe -> DONE (or CHK with option).
- DONE: core_rst_n=1, done=1, busy=0, in_ready=0.
- ERROR: core_rst_n=0, error=1, busy=0, in_ready=0.
- start while busy: ignored. start in DONE/ERROR: restarts as from IDLE (core_rst_n drops to 0 same cycle state leaves DONE).
- in_valid deasserted mid-word: byte counter holds; no timeout.
- rst mid-load: all outputs to reset values immediately; memory contents already written are not cleared.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined: after last data word, state CHK accepts one byte; compared against XOR of all LEN and data bytes. Match -> DONE; mismatch -> ERROR (core stays in reset).
- Undefined: no CHK state; last word -> DONE directly; no checksum byte consumed.

Test Plan:
- Reset then idle 10 cycles -> core_rst_n=0, in_ready=0, imem_we=0, done=0, error=0.
- start, bytes 00 02 12 34 56 78 9A BC DE F0 back-to-back -> two imem_we pulses: addr 0 data 0x12345678, addr 1 data 0x9ABCDEF0; words_loaded=2; done=1, core_rst_n=1.
- start, LEN 00 00 -> DONE immediately after LEN_LO accept, no imem_we, core_rst_n=1.
- ADDR_W=8, LEN 01 01 (257) -> error=1, core_rst_n=0, no imem_we.
- in_valid toggled 1/0 each cycle during a 1-word load 00 01 AA BB CC DD -> single write 0xAABBCCDD at BASE_ADDR; assert rst after 2 data bytes in a second load -> all outputs reset values.
- With IMEM_LOADER_CHECKSUM_EN: 00 01 11 22 33 44 + checksum 0x45 -> done=1; same with 0x00 -> error=1, core_rst_n=0.
